mix_word_decoder: RTL

Receive-side counterpart of the mode-selected add/pass word encoder. Each accepted frame carries a mode pair, a shared key A and an encoded word R. The block recovers operand B:
- pass mode: B is the low bits of R.
- add mode: B = R − A.

It flags malformed frames, keeps a saturating error count, and delivers results through a 2-stage valid/ready pipeline with full backpressure.

---
 rtl/mix_word_decoder.sv | 112 +++++++++++
 1 files changed

// File: rtl/mix_word_decoder.sv
// Receive-side add/pass word decoder: recovers operand B from (mode, A, R),
// flags malformed frames and counts delivered errors behind a 2-stage valid/ready pipe.
module mix_word_decoder #(
  parameter int W     = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [W-1:0]     in_key,
  input  logic [W:0]       in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  // stage 1: registered frame
  logic             s1_vld_q;
  logic             s1_sel_q;
  logic [W-1:0]     s1_key_q;
  logic [W:0]       s1_word_q;

  // stage 2: registered result
  logic             s2_vld_q;
  logic [W-1:0]     s2_data_q;
  logic             s2_err_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_load, s2_load, s2_xfer;
  logic [W:0]       key_ext, diff;
  logic             borrow;
  logic [W-1:0]     dec_data;
  logic             dec_err;

  assign s2_xfer  = s2_vld_q & out_ready;
  assign s2_load  = s1_vld_q & (~s2_vld_q | out_ready);
  // the only combinational output path: out_ready -> in_ready
  assign in_ready = ~rst & (~s1_vld_q | s2_load);
  assign s1_load  = in_valid & in_ready;

  assign key_ext  = {1'b0, s1_key_q};
  assign diff     = s1_word_q - key_ext;
  assign borrow   = (s1_word_q < key_ext);

  always_comb begin
    dec_data = '0;
    dec_err  = 1'b0;
    if (s1_sel_q) begin
      dec_data = s1_word_q[W-1:0];
      dec_err  = s1_word_q[W];
    end else begin
      dec_data = diff[W-1:0];
      dec_err  = borrow | diff[W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_sel_q  <= 1'b0;
      s1_key_q  <= '0;
      s1_word_q <= '0;
    end else if (s1_load) begin
      s1_vld_q  <= 1'b1;
      s1_sel_q  <= ~(in_mode[1] ^ in_mode[0]);
      s1_key_q  <= in_key;
      s1_word_q <= in_word;
    end else if (s2_load) begin
      s1_vld_q  <= 1'b0;
    end
  end

  // s2 holds its contents while stalled, so outputs stay stable under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_err_q  <= 1'b0;
    end else if (s2_load) begin
      s2_vld_q  <= 1'b1;
      s2_data_q <= dec_data;
      s2_err_q  <= dec_err;
    end else if (s2_xfer) begin
      s2_vld_q  <= 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (err_clr)
      cnt_d = '0;
    else if (s2_xfer && s2_err_q && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_valid = s2_vld_q;
  assign out_data  = s2_data_q;
  assign out_err   = s2_err_q;
  assign err_count = cnt_q;

endmodule
